// File: rtl/thumb_branch_unit_pkg.sv
// Shared constants and types for the Thumb execute-stage branch resolver.
package thumb_branch_unit_pkg;

  localparam logic [3:0] F16_OP  = 4'b1101;
  localparam logic [4:0] F18_OP  = 5'b11100;
  localparam logic [4:0] F19H_OP = 5'b11110;
  localparam logic [4:0] F19L_OP = 5'b11111;

  // Architectural PC runs this far ahead of the instruction address
  localparam logic [31:0] PC_OFFSET = 32'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BL_HI  = 2'd1,
    REFILL = 2'd2
  } br_state_e;

endpackage

// File: rtl/thumb_branch_target.sv
// Combinational offset extend/shift/add for every Thumb branch format.
module thumb_branch_target
  import thumb_branch_unit_pkg::*;
(
  input  logic [10:0] offset,
  input  logic [31:0] pc,
  input  logic [31:0] lr_hi,
  input  logic [31:0] lr_in,
  input  logic        use_lr_hi,
  output logic [31:0] cond_target,
  output logic [31:0] uncond_target,
  output logic [31:0] bl_hi_value,
  output logic [31:0] bl_target,
  output logic [31:0] bl_link
);

  logic [31:0] off8_sx;
  logic [31:0] off11_sx;
  logic [31:0] off11_hi;
  logic [31:0] off11_zx;
  logic [31:0] bl_base;

  always_comb begin
    off8_sx  = {{23{offset[7]}}, offset[7:0], 1'b0};
    off11_sx = {{20{offset[10]}}, offset, 1'b0};
    off11_hi = {{9{offset[10]}}, offset, 12'b0};
    off11_zx = {20'b0, offset, 1'b0};
    bl_base  = use_lr_hi ? lr_hi : lr_in;

    cond_target   = (pc + off8_sx) & ~32'd1;
    uncond_target = (pc + off11_sx) & ~32'd1;
    bl_hi_value   = pc + off11_hi;
    bl_target     = (bl_base + off11_zx) & ~32'd1;
    // Return address is the instruction after the suffix, with the Thumb bit set
    bl_link       = (pc - PC_OFFSET + 32'd2) | 32'd1;
  end

endmodule

// File: rtl/thumb_branch_unit.sv
// Execute-stage branch resolver: formats 16/18/19, PC redirect, LR write and refill.
module thumb_branch_unit
  import thumb_branch_unit_pkg::*;
#(
  parameter int unsigned REFILL_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IR_VALID,
  input  logic [15:0] IR,
  input  logic [31:0] PC,
  input  logic        COND_TRUE,
  input  logic [31:0] LR_IN,
  input  logic        STALL,
  output logic        BR_TAKEN,
  output logic [31:0] BR_TARGET,
  output logic        FLUSH,
  output logic        LR_WE,
  output logic [31:0] LR_WDATA,
  output logic        BUSY
);

  localparam int unsigned CNT_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

  br_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       lr_hi_q, lr_hi_d;
  logic              br_taken_d, flush_d, lr_we_d, busy_d;
  logic [31:0]       target_d, lr_wdata_d;

  logic              is_f16, is_f18, is_f19h, is_f19l, taken;
  logic [31:0]       cond_target, uncond_target, bl_hi_value, bl_target, bl_link;

  thumb_branch_target u_target (
    .offset        (IR[10:0]),
    .pc            (PC),
    .lr_hi         (lr_hi_q),
    .lr_in         (LR_IN),
    .use_lr_hi     (state_q == BL_HI),
    .cond_target   (cond_target),
    .uncond_target (uncond_target),
    .bl_hi_value   (bl_hi_value),
    .bl_target     (bl_target),
    .bl_link       (bl_link)
  );

  // Condition codes 1110/1111 in the F16 slot are not conditional branches
  assign is_f16  = (IR[15:12] == F16_OP) && (IR[11:9] != 3'b111);
  assign is_f18  = (IR[15:11] == F18_OP);
  assign is_f19h = (IR[15:11] == F19H_OP);
  assign is_f19l = (IR[15:11] == F19L_OP);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lr_hi_q   <= '0;
      BR_TAKEN  <= 1'b0;
      FLUSH     <= 1'b0;
      LR_WE     <= 1'b0;
      BUSY      <= 1'b0;
      BR_TARGET <= '0;
      LR_WDATA  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lr_hi_q   <= lr_hi_d;
      BR_TAKEN  <= br_taken_d;
      FLUSH     <= flush_d;
      LR_WE     <= lr_we_d;
      BUSY      <= busy_d;
      BR_TARGET <= target_d;
      LR_WDATA  <= lr_wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lr_hi_d    = lr_hi_q;
    br_taken_d = 1'b0;
    flush_d    = 1'b0;
    lr_we_d    = 1'b0;
    target_d   = BR_TARGET;
    lr_wdata_d = LR_WDATA;
    taken      = 1'b0;

    if (!STALL) begin
      if (state_q == REFILL) begin
        if (cnt_q == CNT_W'(REFILL_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (IR_VALID) begin
        state_d = IDLE;
        if (is_f16) begin
          if (COND_TRUE) begin
            taken    = 1'b1;
            target_d = cond_target;
          end
        end else if (is_f18) begin
          taken    = 1'b1;
          target_d = uncond_target;
        end else if (is_f19h) begin
          lr_hi_d    = bl_hi_value;
          lr_we_d    = 1'b1;
          lr_wdata_d = bl_hi_value;
          state_d    = BL_HI;
        end else if (is_f19l) begin
          taken      = 1'b1;
          target_d   = bl_target;
          lr_we_d    = 1'b1;
          lr_wdata_d = bl_link;
        end

        if (taken) begin
          state_d    = REFILL;
          cnt_d      = '0;
          br_taken_d = 1'b1;
          flush_d    = 1'b1;
        end
      end
    end

    busy_d = (state_d == REFILL);
  end

endmodule

// File: tb/tb_thumb_branch_unit.sv
// Directed self-checking bench for thumb_branch_unit.
`timescale 1ns/1ps
module tb_thumb_branch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IR_VALID;
  logic [15:0] IR;
  logic [31:0] PC;
  logic        COND_TRUE;
  logic [31:0] LR_IN;
  logic        STALL;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic        FLUSH;
  logic        LR_WE;
  logic [31:0] LR_WDATA;
  logic        BUSY;

  int tests  = 0;
  int failed = 0;

  thumb_branch_unit #(.REFILL_CYCLES(2)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IR_VALID  (IR_VALID),
    .IR        (IR),
    .PC        (PC),
    .COND_TRUE (COND_TRUE),
    .LR_IN     (LR_IN),
    .STALL     (STALL),
    .BR_TAKEN  (BR_TAKEN),
    .BR_TARGET (BR_TARGET),
    .FLUSH     (FLUSH),
    .LR_WE     (LR_WE),
    .LR_WDATA  (LR_WDATA),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] ir, input logic [31:0] pc, input logic cond);
    IR_VALID  = 1'b1;
    IR        = ir;
    PC        = pc;
    COND_TRUE = cond;
  endtask

  initial begin
    RESET = 1'b1; IR_VALID = 1'b0; IR = '0; PC = '0;
    COND_TRUE = 1'b0; LR_IN = '0; STALL = 1'b0;
    cyc(); cyc();
    RESET = 1'b0;
    check("rst_taken",  32'(BR_TAKEN), 32'h0);
    check("rst_flush",  32'(FLUSH),    32'h0);
    check("rst_lrwe",   32'(LR_WE),    32'h0);
    check("rst_busy",   32'(BUSY),     32'h0);
    check("rst_target", BR_TARGET,     32'h0);
    check("rst_lrdata", LR_WDATA,      32'h0);

    // BEQ backwards, taken; an F18 offered during refill must be ignored
    issue(16'hD0FE, 32'h108, 1'b1);
    cyc();
    check("beq_taken",  32'(BR_TAKEN), 32'h1);
    check("beq_flush",  32'(FLUSH),    32'h1);
    check("beq_target", BR_TARGET,     32'h104);
    check("beq_busy0",  32'(BUSY),     32'h1);
    check("beq_lrwe",   32'(LR_WE),    32'h0);
    issue(16'hE7FE, 32'h500, 1'b0);
    cyc();
    check("refill_taken", 32'(BR_TAKEN), 32'h0);
    check("refill_flush", 32'(FLUSH),    32'h0);
    check("beq_busy1",    32'(BUSY),     32'h1);
    cyc();
    IR_VALID = 1'b0;
    check("refill_ignore", 32'(BR_TAKEN), 32'h0);
    check("beq_busy2",     32'(BUSY),     32'h0);
    check("target_hold",   BR_TARGET,     32'h104);

    // BEQ not taken, then B accepted immediately after
    issue(16'hD0FE, 32'h108, 1'b0);
    cyc();
    check("bne_taken", 32'(BR_TAKEN), 32'h0);
    check("bne_busy",  32'(BUSY),     32'h0);
    issue(16'hE7FE, 32'h200, 1'b0);
    cyc();
    IR_VALID = 1'b0;
    check("b_taken",  32'(BR_TAKEN), 32'h1);
    check("b_target", BR_TARGET,     32'h1FC);
    check("b_lrwe",   32'(LR_WE),    32'h0);
    cyc(); cyc();
    check("b_busy_end", 32'(BUSY), 32'h0);

    // Forward conditional branch and the undefined 1110 condition
    issue(16'hD105, 32'h100, 1'b1);
    cyc();
    IR_VALID = 1'b0;
    check("bfwd_target", BR_TARGET, 32'h10A);
    cyc(); cyc();
    issue(16'hDE05, 32'h100, 1'b1);
    cyc();
    IR_VALID = 1'b0;
    check("cond_e_taken", 32'(BR_TAKEN), 32'h0);
    check("cond_e_busy",  32'(BUSY),     32'h0);

    // BL pair: suffix must use the prefix result, not LR_IN
    LR_IN = 32'hDEAD0000;
    issue(16'hF000, 32'h1004, 1'b0);
    cyc();
    check("blh_lrwe",   32'(LR_WE),    32'h1);
    check("blh_lrdata", LR_WDATA,      32'h1004);
    check("blh_taken",  32'(BR_TAKEN), 32'h0);
    issue(16'hF810, 32'h1006, 1'b0);
    cyc();
    IR_VALID = 1'b0;
    check("bll_taken",  32'(BR_TAKEN), 32'h1);
    check("bll_target", BR_TARGET,     32'h1024);
    check("bll_lrwe",   32'(LR_WE),    32'h1);
    check("bll_lrdata", LR_WDATA,      32'h1005);
    cyc();
    check("bll_lrwe_pulse", 32'(LR_WE), 32'h0);
    check("lrdata_hold",    LR_WDATA,   32'h1005);
    cyc();

    // Orphan suffix falls back to LR_IN
    LR_IN = 32'h3000;
    issue(16'hF810, 32'h2006, 1'b0);
    cyc();
    IR_VALID = 1'b0;
    check("orph_target", BR_TARGET, 32'h3020);
    check("orph_lrdata", LR_WDATA,  32'h2005);
    cyc(); cyc();

    // Broken pair: non-suffix after prefix drops back to IDLE
    issue(16'hF000, 32'h1004, 1'b0);
    cyc();
    issue(16'h2001, 32'h1006, 1'b0);
    cyc();
    check("brk_taken", 32'(BR_TAKEN), 32'h0);
    check("brk_lrwe",  32'(LR_WE),    32'h0);
    issue(16'hF810, 32'h2006, 1'b0);
    cyc();
    IR_VALID = 1'b0;
    check("brk_suffix_target", BR_TARGET, 32'h3020);
    cyc(); cyc();

    // Stall through refill stretches BUSY by the stalled cycles
    issue(16'hE7FE, 32'h200, 1'b0);
    cyc();
    IR_VALID = 1'b0;
    STALL = 1'b1;
    check("stl_taken", 32'(BR_TAKEN), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stl_busy_hold", 32'(BUSY),     32'h1);
      check("stl_no_pulse",  32'(BR_TAKEN), 32'h0);
    end
    STALL = 1'b0;
    cyc();
    check("stl_busy_last", 32'(BUSY), 32'h1);
    cyc();
    check("stl_busy_end", 32'(BUSY), 32'h0);

    // Stall blocks acceptance in IDLE
    issue(16'hE7FE, 32'h300, 1'b0);
    STALL = 1'b1;
    cyc();
    check("stl_idle_taken", 32'(BR_TAKEN), 32'h0);
    check("stl_idle_busy",  32'(BUSY),     32'h0);
    STALL = 1'b0;
    cyc();
    IR_VALID = 1'b0;
    check("unstl_taken",  32'(BR_TAKEN), 32'h1);
    check("unstl_target", BR_TARGET,     32'h2FC);

    // Reset mid-refill clears everything; next IR accepted right away
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    check("mrst_busy",   32'(BUSY),     32'h0);
    check("mrst_taken",  32'(BR_TAKEN), 32'h0);
    check("mrst_target", BR_TARGET,     32'h0);
    check("mrst_lrdata", LR_WDATA,      32'h0);
    issue(16'hD0FE, 32'h108, 1'b1);
    cyc();
    IR_VALID = 1'b0;
    check("post_rst_taken",  32'(BR_TAKEN), 32'h1);
    check("post_rst_target", BR_TARGET,     32'h104);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
